// File: rtl/conv_out_lane_scheduler.sv
// conv_out_lane_scheduler: steers adder words into lane FIFOs,
// then drains the lanes into one serialized pixel stream.
module conv_out_lane_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int LANES          = 8,
  parameter int LANE_DEPTH     = 64,
  parameter int LANE_IDX_WIDTH = 3,
  parameter int CNT_WIDTH      = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [LANES-1:0]            lane_full,
  input  logic [LANES-1:0]            lane_empty,
  input  logic [LANES*DATA_WIDTH-1:0] lane_dout,
  output logic [LANES-1:0]            lane_wr_en,
  output logic [LANES-1:0]            lane_rd_en,
  output logic [DATA_WIDTH-1:0]       pxl_out,
  output logic                        valid_out,
  output logic                        pass_done,
  output logic                        err_drop
);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT =
    CNT_WIDTH'(LANE_DEPTH - 1);
  localparam logic [LANE_IDX_WIDTH-1:0] LAST_LANE =
    LANE_IDX_WIDTH'(LANES - 1);

  state_t                    state;
  logic [LANE_IDX_WIDTH-1:0] wr_lane;
  logic [LANE_IDX_WIDTH-1:0] rd_lane;
  logic [LANE_IDX_WIDTH-1:0] rd_sel;
  logic [LANE_IDX_WIDTH-1:0] s1_sel;
  logic [CNT_WIDTH-1:0]      wr_cnt;
  logic [CNT_WIDTH-1:0]      rd_cnt;
  logic                      rd_last;
  logic                      s1_valid;
  logic                      s1_last;
  logic                      wr_ok;
  logic                      drop;
  logic                      rd_ok;
  logic [DATA_WIDTH-1:0]     sel_word;

  assign wr_ok = (state == FILL) & valid_in
               & ~lane_full[wr_lane];
  assign drop  = valid_in & ~wr_ok;
  assign rd_ok = (state == DRAIN)
               & ~lane_empty[rd_lane];

  // one-hot write strobe toward the current fill lane
  always_comb begin
    lane_wr_en = '0;
    if (wr_ok) lane_wr_en[wr_lane] = 1'b1;
  end

  // phase FSM, fill/drain counters and registered read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      wr_lane    <= '0;
      wr_cnt     <= '0;
      rd_lane    <= '0;
      rd_cnt     <= '0;
      lane_rd_en <= '0;
      rd_sel     <= '0;
      rd_last    <= 1'b0;
      err_drop   <= 1'b0;
    end else begin
      lane_rd_en <= '0;
      rd_last    <= 1'b0;
      if (drop) err_drop <= 1'b1;
      unique case (state)
        FILL: begin
          if (wr_ok) begin
            if (wr_cnt == LAST_CNT) begin
              wr_cnt <= '0;
              if (wr_lane == LAST_LANE) begin
                wr_lane <= '0;
                state   <= DRAIN;
              end else begin
                wr_lane <= wr_lane + 1'b1;
              end
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (rd_ok) begin
            lane_rd_en[rd_lane] <= 1'b1;
            rd_sel              <= rd_lane;
            if (rd_cnt == LAST_CNT) begin
              rd_cnt <= '0;
              if (rd_lane == LAST_LANE) begin
                rd_lane <= '0;
                rd_last <= 1'b1;
                state   <= FILL;
              end else begin
                rd_lane <= rd_lane + 1'b1;
              end
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // carry lane index and last flag across the FIFO read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= |lane_rd_en;
      s1_sel   <= rd_sel;
      s1_last  <= rd_last;
    end
  end

  // pick the word of the lane read last cycle
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s1_sel == LANE_IDX_WIDTH'(k))
        sel_word = lane_dout[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // registered serialized pixel stream; pixel holds when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_out   <= '0;
      valid_out <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      pass_done <= s1_valid & s1_last;
      if (s1_valid) pxl_out <= sel_word;
    end
  end

endmodule

// File: tb/tb_conv_out_lane_scheduler.sv
// tb_conv_out_lane_scheduler: small (2x4) and default (8x64)
// instances against behavioural FIFOs and a pass-level model.
module tb_conv_out_lane_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] vin;
  logic [31:0] din [2];
  logic [7:0] fmask [2];

  logic [1:0]   s_full, s_empty, s_wr, s_rd;
  logic [63:0]  s_dout;
  logic [31:0]  s_px;
  logic         s_vo, s_pd, s_err;
  logic [7:0]   b_full, b_empty, b_wr, b_rd;
  logic [255:0] b_dout;
  logic [31:0]  b_px;
  logic         b_vo, b_pd, b_err;

  always #5 clk = ~clk;

  conv_out_lane_scheduler #(
    .DATA_WIDTH(32), .LANES(2), .LANE_DEPTH(4),
    .LANE_IDX_WIDTH(1), .CNT_WIDTH(3)
  ) u_small (
    .clk(clk), .reset(reset), .valid_in(vin[0]),
    .lane_full(s_full), .lane_empty(s_empty),
    .lane_dout(s_dout), .lane_wr_en(s_wr),
    .lane_rd_en(s_rd), .pxl_out(s_px),
    .valid_out(s_vo), .pass_done(s_pd),
    .err_drop(s_err)
  );

  conv_out_lane_scheduler u_big (
    .clk(clk), .reset(reset), .valid_in(vin[1]),
    .lane_full(b_full), .lane_empty(b_empty),
    .lane_dout(b_dout), .lane_wr_en(b_wr),
    .lane_rd_en(b_rd), .pxl_out(b_px),
    .valid_out(b_vo), .pass_done(b_pd),
    .err_drop(b_err)
  );

  function automatic int lnf(input int i);
    return (i == 0) ? 2 : 8;
  endfunction

  function automatic int dpf(input int i);
    return (i == 0) ? 4 : 64;
  endfunction

  logic [7:0]  wra [2];
  logic [7:0]  rda [2];
  logic [31:0] pxa [2];
  logic [1:0]  voa, pda, era;
  assign wra[0] = {6'd0, s_wr};
  assign wra[1] = b_wr;
  assign rda[0] = {6'd0, s_rd};
  assign rda[1] = b_rd;
  assign pxa[0] = s_px;
  assign pxa[1] = b_px;
  assign voa = {b_vo, s_vo};
  assign pda = {b_pd, s_pd};
  assign era = {b_err, s_err};

  // behavioural lane FIFOs, depth equal to one pass per lane
  logic [31:0] mem [2][8][64];
  logic [31:0] fq [2][8];
  int cnt [2][8];
  int wp [2][8];
  int rp [2][8];
  logic [7:0] ff [2];
  logic [7:0] fe [2];
  logic [255:0] dpk [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (reset) begin
          cnt[i][k] <= 0;
          wp[i][k]  <= 0;
          rp[i][k]  <= 0;
          fq[i][k]  <= '0;
        end else begin
          if (wra[i][k]) begin
            mem[i][k][wp[i][k]] <= din[i];
            wp[i][k] <= (wp[i][k] + 1) % dpf(i);
          end
          if (rda[i][k]) begin
            fq[i][k] <= mem[i][k][rp[i][k]];
            rp[i][k] <= (rp[i][k] + 1) % dpf(i);
          end
          cnt[i][k] <= cnt[i][k] + (wra[i][k] ? 1 : 0)
                     - (rda[i][k] ? 1 : 0);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dpk[i] = '0;
      for (int k = 0; k < 8; k++) begin
        ff[i][k] = (cnt[i][k] >= dpf(i));
        fe[i][k] = (cnt[i][k] == 0);
        dpk[i][k*32 +: 32] = fq[i][k];
      end
    end
  end

  assign s_full  = ff[0][1:0];
  assign s_empty = fe[0][1:0] | fmask[0][1:0];
  assign s_dout  = dpk[0][63:0];
  assign b_full  = ff[1];
  assign b_empty = fe[1] | fmask[1];
  assign b_dout  = dpk[1];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pass-level model: output k of a pass is accepted word k
  int ph [2];
  int acc [2];
  int rds [2];
  bit merr [2];
  logic [31:0] words [2][512];
  logic [7:0] xrd [2];
  bit s0v [2], s1v [2], ov [2];
  bit s0l [2], s1l [2], ol [2];
  logic [31:0] s0d [2], s1d [2], od [2];
  bit armed = 1'b0;
  int cyc = 0;
  logic [7:0] xwr, nrd;
  int li;
  bit nv, nl;
  logic [31:0] nd;

  logic [31:0] wlog [$];
  logic [31:0] olog [$];
  logic [31:0] olog1 [$];
  int wcyc [$];
  int ocyc [$];
  int rcyc [$];
  int pcyc [$];
  int pdn1 = 0;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        xwr = '0;
        li = acc[i] / dpf(i);
        if (ph[i] == 0 && vin[i] && !ff[i][li])
          xwr[li] = 1'b1;
        chk($sformatf("wr_en%0d", i), 32'(wra[i]), 32'(xwr));
        chk($sformatf("rd_en%0d", i), 32'(rda[i]), 32'(xrd[i]));
        chk($sformatf("valid%0d", i), 32'(voa[i]), 32'(ov[i]));
        chk($sformatf("pxl%0d", i), pxa[i], od[i]);
        chk($sformatf("done%0d", i), 32'(pda[i]), 32'(ol[i]));
        chk($sformatf("err%0d", i), 32'(era[i]), 32'(merr[i]));
      end
      if (wra[0] != 0) begin
        wlog.push_back(32'(wra[0]));
        wcyc.push_back(cyc);
      end
      if (rda[0] != 0) rcyc.push_back(cyc);
      if (voa[0]) begin
        olog.push_back(pxa[0]);
        ocyc.push_back(cyc);
      end
      if (pda[0]) pcyc.push_back(cyc);
      if (voa[1]) olog1.push_back(pxa[1]);
      if (pda[1]) pdn1++;
    end
    if (reset) begin
      armed = 1'b1;
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; acc[i] = 0; rds[i] = 0; merr[i] = 1'b0;
        xrd[i] = '0;
        s0v[i] = 1'b0; s1v[i] = 1'b0; ov[i] = 1'b0;
        s0l[i] = 1'b0; s1l[i] = 1'b0; ol[i] = 1'b0;
        s0d[i] = '0; s1d[i] = '0; od[i] = '0;
      end
    end else if (armed) begin
      for (int i = 0; i < 2; i++) begin
        nv = 1'b0; nl = 1'b0; nd = '0; nrd = '0;
        if (ph[i] == 0) begin
          if (vin[i]) begin
            li = acc[i] / dpf(i);
            if (!ff[i][li]) begin
              words[i][acc[i]] = din[i];
              acc[i]++;
              if (acc[i] == lnf(i) * dpf(i)) begin
                ph[i] = 1;
                rds[i] = 0;
              end
            end else begin
              merr[i] = 1'b1;
            end
          end
        end else begin
          if (vin[i]) merr[i] = 1'b1;
          li = rds[i] / dpf(i);
          if (!(fe[i][li] | fmask[i][li])) begin
            nv = 1'b1;
            nd = words[i][rds[i]];
            nl = (rds[i] == lnf(i) * dpf(i) - 1);
            nrd[li] = 1'b1;
            rds[i]++;
            if (rds[i] == lnf(i) * dpf(i)) begin
              ph[i] = 0;
              acc[i] = 0;
            end
          end
        end
        ov[i] = s1v[i];
        if (s1v[i]) od[i] = s1d[i];
        ol[i] = s1v[i] & s1l[i];
        s1v[i] = s0v[i]; s1d[i] = s0d[i]; s1l[i] = s0l[i];
        s0v[i] = nv; s0d[i] = nd; s0l[i] = nl;
        xrd[i] = nrd;
      end
    end
  end

  int wb, ob, rb, pb, sent, ob1, pb1, bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill0(input int n, input int gap);
    for (int j = 1; j <= n; j++) begin
      vin[0] = 1'b1;
      din[0] = j;
      tick();
      vin[0] = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic mark();
    wb = wlog.size();
    ob = olog.size();
    rb = rcyc.size();
    pb = pcyc.size();
  endtask

  task automatic check_pass(input string t, input int dly);
    chk({t, "_wr_n"}, wlog.size() - wb, 8);
    chk({t, "_out_n"}, olog.size() - ob, 8);
    chk({t, "_done_n"}, pcyc.size() - pb, 1);
    if (wlog.size() - wb >= 8 && olog.size() - ob >= 8 &&
        rcyc.size() > rb && pcyc.size() > pb) begin
      for (int j = 0; j < 8; j++) begin
        chk({t, "_wr"}, wlog[wb+j], (j < 4) ? 1 : 2);
        chk({t, "_px"}, olog[ob+j], j + 1);
      end
      chk({t, "_contig"}, ocyc[ob+7] - ocyc[ob], 7);
      chk({t, "_lat"}, ocyc[ob] - rcyc[rb], 2);
      chk({t, "_dly"}, ocyc[ob] - wcyc[wb+7], dly);
      chk({t, "_done_at"}, pcyc[pb], ocyc[ob+7]);
    end
  endtask

  initial begin
    vin = '0;
    din[0] = '0; din[1] = '0;
    fmask[0] = '0; fmask[1] = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_rd", 32'(s_rd), 0);
    chk("rst_vo", 32'(s_vo), 0);
    chk("rst_px", s_px, 0);
    chk("rst_pd", 32'(s_pd), 0);
    chk("rst_err", 32'(s_err), 0);
    chk("rst_big_rd", 32'(b_rd), 0);

    mark();
    fill0(8, 0);
    repeat (20) tick();
    check_pass("t1", 4);
    chk("t1_err", 32'(s_err), 0);

    mark();
    fill0(8, 2);
    repeat (20) tick();
    check_pass("t2", 4);
    chk("t2_err", 32'(s_err), 0);

    mark();
    fill0(8, 0);
    fmask[0] = 8'h01;
    repeat (3) tick();
    fmask[0] = 8'h00;
    repeat (20) tick();
    check_pass("t3", 7);

    mark();
    fill0(8, 0);
    vin[0] = 1'b1;
    din[0] = 32'd99;
    repeat (5) tick();
    vin[0] = 1'b0;
    repeat (20) tick();
    check_pass("t4", 4);
    chk("t4_err", 32'(s_err), 1);
    repeat (10) tick();
    chk("t4_err_hold", 32'(s_err), 1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("t4_err_clr", 32'(s_err), 0);

    fill0(5, 0);
    reset = 1'b1;
    tick();
    chk("t5_rd", 32'(s_rd), 0);
    chk("t5_vo", 32'(s_vo), 0);
    chk("t5_px", s_px, 0);
    chk("t5_pd", 32'(s_pd), 0);
    reset = 1'b0;
    tick();
    mark();
    fill0(8, 0);
    repeat (20) tick();
    check_pass("t5", 4);

    sent = 0;
    ob1 = olog1.size();
    pb1 = pdn1;
    for (int c = 0; c < 6000 && sent < 1024; c++) begin
      if (ph[1] == 0) begin
        vin[1] = 1'b1;
        din[1] = sent + 1;
        sent++;
      end else begin
        vin[1] = 1'b0;
      end
      tick();
    end
    vin[1] = 1'b0;
    for (int c = 0; c < 2000 && olog1.size() - ob1 < 1024; c++)
      tick();
    repeat (4) tick();
    chk("big_sent", sent, 1024);
    chk("big_out_n", olog1.size() - ob1, 1024);
    bad = 0;
    for (int j = 0; j < 1024; j++) begin
      if (ob1 + j < olog1.size()) begin
        if (olog1[ob1+j] !== 32'(j + 1)) bad++;
      end
    end
    chk("big_order_bad", bad, 0);
    chk("big_done_n", pdn1 - pb1, 2);
    chk("big_err", 32'(b_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
